// File: rtl/ca_pkg.sv
// Shared widths, defaults and the register-write payload used by the write arbiter.
package ca_pkg;

    localparam int unsigned REG_ADDR_W           = 5;
    localparam int unsigned DATA_W               = 32;
    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;
    localparam int unsigned FIFO_DEPTH_DEFAULT   = 2;

    // One register-file write: destination plus data.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] regAddr;
        logic [DATA_W-1:0]     data;
    } wrReq_t;

    // Register 0 is hardwired to zero, so writes to it are suppressed.
    function automatic logic writesReg(input logic [REG_ADDR_W-1:0] addr);
        return addr != '0;
    endfunction

endpackage

// File: rtl/md_req_fifo.sv
// Small circular buffer holding mult/div write requests until they win the write port.
module md_req_fifo
    import ca_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  wrReq_t pushReq,
    input  logic   pop,
    output wrReq_t headReq,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wrReq_t           mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] count;
    logic             doPush;
    logic             doPop;

    // Pointers wrap at DEPTH so non-power-of-two depths work too.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign doPop   = pop && !empty;
    // A pop frees the slot in the same cycle, so a full buffer may still take a push.
    assign doPush  = push && (!full || doPop);
    assign headReq = mem[rdPtr];

    // Payload storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushReq;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= nextPtr(wrPtr);
            end
            if (doPop) begin
                rdPtr <= nextPtr(rdPtr);
            end
            if (doPush && !doPop) begin
                count <= count + CNT_W'(1);
            end else if (doPop && !doPush) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between the WB stage and the mult/div unit.
module regfile_write_arbiter
    import ca_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  md_valid,
    output logic                  md_ready,
    input  logic [REG_ADDR_W-1:0] md_reg,
    input  logic [DATA_W-1:0]     md_data,
    output logic                  pipe_stall,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0]     WriteData
);

    localparam int unsigned STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    wrReq_t              mdReq;
    wrReq_t              headReq;
    wrReq_t              grantReq;
    logic                fifoFull;
    logic                fifoEmpty;
    logic                mdPush;
    logic                grantMd;
    logic                grantWb;
    logic [STARVE_W-1:0] starveCnt;

    assign md_ready      = !fifoFull && !rst;
    assign mdPush        = md_valid && md_ready;
    assign pipe_stall    = (starveCnt == STARVE_W'(STARVE_LIMIT));
    assign mdReq.regAddr = md_reg;
    assign mdReq.data    = md_data;

    md_req_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_mdFifo (
        .clk    (clk),
        .rst    (rst),
        .push   (mdPush),
        .pushReq(mdReq),
        .pop    (grantMd),
        .headReq(headReq),
        .full   (fifoFull),
        .empty  (fifoEmpty)
    );

    // Grant: WB wins unless the MD head has starved long enough to stall the pipe.
    always_comb begin
        grantMd  = 1'b0;
        grantWb  = 1'b0;
        grantReq = '0;
        if (!fifoEmpty && (!wb_valid || pipe_stall)) begin
            grantMd  = 1'b1;
            grantReq = headReq;
        end else if (wb_valid && !pipe_stall) begin
            grantWb          = 1'b1;
            grantReq.regAddr = wb_reg;
            grantReq.data    = wb_data;
        end
    end

    // Counts cycles the MD head has waited; saturates at the stall threshold.
    always_ff @(posedge clk) begin
        if (rst) begin
            starveCnt <= '0;
        end else if (fifoEmpty || grantMd) begin
            starveCnt <= '0;
        end else if (!pipe_stall) begin
            starveCnt <= starveCnt + STARVE_W'(1);
        end
    end

    // Register the granted write; address/data hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            RegWrite <= (grantMd || grantWb) && writesReg(grantReq.regAddr);
            if (grantMd || grantWb) begin
                WriteRegister <= grantReq.regAddr;
                WriteData     <= grantReq.data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic against a queue model.
module tb_regfile_write_arbiter;

    localparam int LIMIT = 4;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_reg;
    logic [31:0] md_data;
    logic        pipe_stall;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .STARVE_LIMIT(LIMIT),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .md_valid     (md_valid),
        .md_ready     (md_ready),
        .md_reg       (md_reg),
        .md_data      (md_data),
        .pipe_stall   (pipe_stall),
        .RegWrite     (RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData)
    );

    // Reference model: pending MD writes as a queue, wait counter as an integer.
    logic [36:0] mq[$];
    int          mStarve    = 0;
    logic        mRegWrite  = 1'b0;
    logic [4:0]  mWriteReg  = '0;
    logic [31:0] mWriteData = '0;
    logic        expReady;
    logic        expStall;
    logic        mAccepted;
    logic        obsReady;
    logic        obsStall;

    task automatic model_step();
        bit          gMd;
        bit          gWb;
        logic [36:0] e;
        if (rst) begin
            mq.delete();
            mStarve    = 0;
            mRegWrite  = 1'b0;
            mWriteReg  = '0;
            mWriteData = '0;
            return;
        end
        gMd = (mq.size() > 0) && (!wb_valid || expStall);
        gWb = !gMd && wb_valid && !expStall;
        if (mq.size() == 0 || gMd) mStarve = 0;
        else if (mStarve < LIMIT) mStarve++;
        if (gMd) begin
            e          = mq.pop_front();
            mRegWrite  = (e[36:32] != 5'd0);
            mWriteReg  = e[36:32];
            mWriteData = e[31:0];
        end else if (gWb) begin
            mRegWrite  = (wb_reg != 5'd0);
            mWriteReg  = wb_reg;
            mWriteData = wb_data;
        end else begin
            mRegWrite = 1'b0;
        end
        if (mAccepted) mq.push_back({md_reg, md_data});
    endtask

    // One clock: sample combinational outputs mid-cycle, advance the model at the edge.
    task automatic cycle();
        expReady  = !rst && (mq.size() < DEPTH);
        expStall  = (mStarve == LIMIT);
        mAccepted = md_valid && expReady;
        #2;
        obsReady = md_ready;
        obsStall = pipe_stall;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0;
        wb_reg   = '0;
        wb_data  = '0;
        md_valid = 1'b0;
        md_reg   = '0;
        md_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic drain();
        idle_inputs();
        for (int i = 0; i < 10 && mq.size() > 0; i++) cycle();
        cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        checks++;
        if (obsReady !== 1'b0) begin
            failures++;
            $display("FAIL reset_md_ready: got %b expected 0", obsReady);
        end
        checks++;
        if ({RegWrite, WriteRegister, WriteData} !== 38'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b/%0d/%h expected 0/0/0", RegWrite, WriteRegister, WriteData);
        end
        rst = 1'b0;
        cycle();
        checks++;
        if (obsStall !== 1'b0 || obsReady !== 1'b1) begin
            failures++;
            $display("FAIL post_reset: stall=%b ready=%b expected 0/1", obsStall, obsReady);
        end
    endtask

    task automatic test_md_only();
        do_reset();
        md_valid = 1'b1;
        md_reg   = 5'd5;
        md_data  = 32'h1234;
        cycle();
        checks++;
        if (obsReady !== 1'b1 || RegWrite !== 1'b0) begin
            failures++;
            $display("FAIL md_only_c1: ready=%b RegWrite=%b expected 1/0", obsReady, RegWrite);
        end
        idle_inputs();
        cycle();
        checks++;
        if (RegWrite !== 1'b1 || WriteRegister !== 5'd5 || WriteData !== 32'h1234) begin
            failures++;
            $display("FAIL md_only_c2: got %b/%0d/%h expected 1/5/1234", RegWrite, WriteRegister, WriteData);
        end
        cycle();
        checks++;
        if (RegWrite !== 1'b0 || WriteRegister !== 5'd5 || WriteData !== 32'h1234) begin
            failures++;
            $display("FAIL md_only_hold: got %b/%0d/%h expected 0/5/1234", RegWrite, WriteRegister, WriteData);
        end
    endtask

    task automatic test_starvation();
        logic [4:0]  firstReg;
        logic [31:0] firstData;
        int          idx;
        do_reset();
        idx       = 0;
        firstReg  = 5'(1 + $urandom_range(0, 30));
        firstData = $urandom;
        wb_valid  = 1'b1;
        md_valid  = 1'b1;
        md_reg    = firstReg;
        md_data   = firstData;
        for (int k = 0; k < 7; k++) begin
            wb_reg  = 5'(1 + $urandom_range(0, 30));
            wb_data = $urandom;
            cycle();
            checks++;
            if (obsStall !== (k == 5)) begin
                failures++;
                $display("FAIL starve_stall_k%0d: got %b expected %b", k, obsStall, (k == 5));
            end
            checks++;
            if (k == 5) begin
                if (RegWrite !== 1'b1 || WriteRegister !== firstReg || WriteData !== firstData) begin
                    failures++;
                    $display("FAIL starve_md_write: got %b/%0d/%h expected 1/%0d/%h",
                             RegWrite, WriteRegister, WriteData, firstReg, firstData);
                end
            end else if (RegWrite !== 1'b1 || WriteData !== wb_data) begin
                failures++;
                $display("FAIL starve_wb_k%0d: got %b/%h expected 1/%h", k, RegWrite, WriteData, wb_data);
            end
            if (mAccepted) begin
                idx++;
                md_reg  = 5'(1 + $urandom_range(0, 30));
                md_data = $urandom;
            end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] sent[$];
        logic [31:0] got[$];
        int          pushes;
        bit          sawFullCheck;
        do_reset();
        pushes       = 0;
        sawFullCheck = 0;
        wb_valid     = 1'b1;
        md_valid     = 1'b1;
        md_reg       = 5'd10;
        md_data      = {16'hBEEF, 16'd0};
        for (int k = 0; k < 12 && pushes < 3; k++) begin
            wb_reg  = 5'(1 + $urandom_range(0, 30));
            wb_data = 32'($urandom_range(0, 32'hFFFF));
            cycle();
            if (pushes == 2 && !sawFullCheck) begin
                sawFullCheck = 1;
                checks++;
                if (obsReady !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_full_ready: got %b expected 0", obsReady);
                end
            end
            if (RegWrite && WriteData[31:16] == 16'hBEEF) got.push_back(WriteData);
            if (mAccepted) begin
                sent.push_back(md_data);
                pushes++;
                md_reg  = 5'(10 + pushes);
                md_data = {16'hBEEF, 16'(pushes)};
            end
        end
        idle_inputs();
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (RegWrite && WriteData[31:16] == 16'hBEEF) got.push_back(WriteData);
        end
        checks++;
        if (got.size() != 3 || sent.size() != 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d writes of %0d sent expected 3", got.size(), sent.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== sent[i]) begin
                    failures++;
                    $display("FAIL b2b_order_%0d: got %h expected %h", i, got[i], sent[i]);
                end
            end
        end
    endtask

    task automatic test_reg_zero();
        do_reset();
        wb_valid = 1'b1;
        wb_reg   = 5'd7;
        wb_data  = 32'h77;
        md_valid = 1'b1;
        md_reg   = 5'd9;
        md_data  = 32'hCAFE_0009;
        cycle();
        md_valid = 1'b0;
        wb_reg   = 5'd0;
        wb_data  = 32'hFFFF;
        cycle();
        checks++;
        if (RegWrite !== 1'b0) begin
            failures++;
            $display("FAIL reg0_regwrite: got %b expected 0", RegWrite);
        end
        idle_inputs();
        cycle();
        checks++;
        if (RegWrite !== 1'b1 || WriteRegister !== 5'd9 || WriteData !== 32'hCAFE_0009) begin
            failures++;
            $display("FAIL reg0_md_after: got %b/%0d/%h expected 1/9/cafe0009", RegWrite, WriteRegister, WriteData);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wb_valid = 1'b1;
        wb_reg   = 5'd3;
        md_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            md_reg  = 5'(20 + k);
            md_data = 32'hDEAD_0000 + 32'(k);
            wb_data = 32'(k);
            cycle();
        end
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if (RegWrite !== 1'b0 || WriteData !== 32'd0) begin
            failures++;
            $display("FAIL rstmid_outputs: got %b/%h expected 0/0", RegWrite, WriteData);
        end
        for (int k = 0; k < 4; k++) begin
            cycle();
            checks++;
            if (RegWrite !== 1'b0 || obsReady !== 1'b1 || obsStall !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_stale_k%0d: RegWrite=%b ready=%b stall=%b expected 0/1/0",
                         k, RegWrite, obsReady, obsStall);
            end
        end
    endtask

    task automatic test_full_pop_push();
        logic [31:0] sent[$];
        logic [31:0] got[$];
        do_reset();
        wb_valid = 1'b1;
        wb_reg   = 5'd2;
        wb_data  = 32'h2;
        md_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) wb_valid = 1'b0;
            md_reg  = 5'(1 + k);
            md_data = {16'hBEEF, 16'(sent.size())};
            cycle();
            checks++;
            if (obsReady !== expReady || RegWrite !== mRegWrite || WriteData !== mWriteData) begin
                failures++;
                $display("FAIL fullpp_k%0d: ready=%b rw=%b wd=%h expected %b/%b/%h",
                         k, obsReady, RegWrite, WriteData, expReady, mRegWrite, mWriteData);
            end
            if (RegWrite && WriteData[31:16] == 16'hBEEF) got.push_back(WriteData);
            if (mAccepted) sent.push_back(md_data);
        end
        idle_inputs();
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (RegWrite && WriteData[31:16] == 16'hBEEF) got.push_back(WriteData);
        end
        checks++;
        if (got.size() != sent.size() || got.size() < 4) begin
            failures++;
            $display("FAIL fullpp_count: got %0d writes of %0d sent", got.size(), sent.size());
        end else begin
            for (int i = 0; i < got.size(); i++) begin
                checks++;
                if (got[i] !== sent[i]) begin
                    failures++;
                    $display("FAIL fullpp_order_%0d: got %h expected %h", i, got[i], sent[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        bit hold;
        hold = 0;
        idle_inputs();
        for (int k = 0; k < 400; k++) begin
            rst      = ($urandom_range(0, 49) == 0);
            wb_valid = ($urandom_range(0, 1) == 1);
            wb_reg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wb_data  = $urandom;
            if (!hold) begin
                if ($urandom_range(0, 9) < 6) begin
                    md_valid = 1'b1;
                    md_reg   = 5'($urandom_range(0, 31));
                    md_data  = $urandom;
                    hold     = 1;
                end else begin
                    md_valid = 1'b0;
                end
            end
            cycle();
            if (mAccepted || rst) begin
                hold     = 0;
                md_valid = 1'b0;
            end
            checks++;
            if (obsReady !== expReady || obsStall !== expStall) begin
                failures++;
                $display("FAIL rand_comb_k%0d: ready=%b stall=%b expected %b/%b",
                         k, obsReady, obsStall, expReady, expStall);
            end
            checks++;
            if (RegWrite !== mRegWrite || WriteRegister !== mWriteReg || WriteData !== mWriteData) begin
                failures++;
                $display("FAIL rand_write_k%0d: got %b/%0d/%h expected %b/%0d/%h",
                         k, RegWrite, WriteRegister, WriteData, mRegWrite, mWriteReg, mWriteData);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_md_only();
        test_starvation();
        test_back_to_back();
        test_reg_zero();
        test_reset_mid();
        test_full_pop_push();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
